// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_fetch_unit_pkg;

   // Fetch controller states: no request, request in flight, request in flight but stale
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR        = 32'd0;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One queued fetch: the address of the next sequential instruction and the fetched word
   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fetch_queue.sv
// Small in-order FIFO of fetched instructions; flush empties it and wins over push/pop.
module fetch_queue
   import if_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  fetch_entry_t push_entry,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   fetch_entry_t     mem [DEPTH];
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count == FULL_COUNT);
   assign empty   = (count == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array; a flushed push is dropped, so nothing is written that cycle
   always_ff @(posedge clk) begin
      if (push_ok && !flush) begin
         mem[wr_ptr] <= push_entry;
      end
   end

   // Pointers and occupancy; flush resets occupancy regardless of push/pop
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push_ok && !pop_ok) begin
            count <= count + 1'b1;
         end else if (pop_ok && !push_ok) begin
            count <= count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/if_fetch_unit.sv
// Pipeline front end: owns the PC, fetches one word at a time over req/ack and queues it.
module if_fetch_unit
   import if_fetch_unit_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        valid_out,
   output logic [31:0] pc_out,
   output logic [31:0] instruction_out
);

   fetch_state_t state;
   fetch_state_t state_next;
   logic [31:0]  fetch_pc;
   logic [31:0]  fetch_pc_next;
   logic [31:0]  drain_addr;
   logic         push;
   logic         pop;
   logic         q_full;
   logic         q_empty;
   fetch_entry_t push_entry;
   fetch_entry_t q_head;

   assign push_entry = '{pc4: fetch_pc + 32'd4, instr: imem_rdata};
   assign pop        = !q_empty && !freeze;

   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .flush      (branch_taken),
      .push_entry (push_entry),
      .full       (q_full),
      .empty      (q_empty),
      .head       (q_head)
   );

   // State, PC and the in-flight address kept for a request that became stale
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         fetch_pc   <= RESET_PC;
         drain_addr <= RESET_PC;
      end else begin
         state    <= state_next;
         fetch_pc <= fetch_pc_next;
         if (state == WAIT && branch_taken && !imem_ack) begin
            drain_addr <= fetch_pc;
         end
      end
   end

   // Next-state, PC update and request handshake; a redirect always discards the current fetch
   always_comb begin
      state_next    = state;
      fetch_pc_next = fetch_pc;
      push          = 1'b0;
      imem_req      = 1'b0;
      imem_addr     = fetch_pc;
      case (state)
         IDLE: begin
            if (branch_taken) begin
               fetch_pc_next = branch_addr;
            end else if (!q_full) begin
               state_next = WAIT;
            end
         end
         WAIT: begin
            imem_req = 1'b1;
            if (branch_taken) begin
               fetch_pc_next = branch_addr;
               state_next    = imem_ack ? IDLE : DRAIN;
            end else if (imem_ack) begin
               push          = 1'b1;
               fetch_pc_next = fetch_pc + 32'd4;
               state_next    = IDLE;
            end
         end
         DRAIN: begin
            imem_req  = 1'b1;
            imem_addr = drain_addr;
            if (branch_taken) begin
               fetch_pc_next = branch_addr;
            end
            if (imem_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign valid_out       = !q_empty;
   assign pc_out          = q_empty ? 32'd0 : q_head.pc4;
   assign instruction_out = q_empty ? NOP_INSTR : q_head.instr;

endmodule
